handler_packet_buffer: RTL

// Store-and-forward packet buffer directly upstream of the kernel handler stage. Accepts AM

---
 rtl/handler_packet_buffer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/handler_packet_buffer.sv
// Store-and-forward AM packet buffer: filters non-local destinations and releases a packet
// to the handler stage only after every beat of it has been written.
module handler_packet_buffer #(
   parameter int NUM_KERNELS    = 2,
   parameter int DEPTH          = 64,
   parameter int DROP_CNT_WIDTH = 16
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic [63:0]               axis_in_tdata,
   input  logic                      axis_in_tlast,
   input  logic                      axis_in_tvalid,
   output logic                      axis_in_tready,
   input  logic [15:0]               address_offset,
   output logic [63:0]               axis_handler_tdata,
   output logic                      axis_handler_tlast,
   output logic                      axis_handler_tvalid,
   input  logic                      axis_handler_tready,
   output logic                      drop_pulse,
   output logic [DROP_CNT_WIDTH-1:0] drop_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [15:0] NK = 16'(NUM_KERNELS);

   typedef enum logic [1:0] {WR_HEADER, WR_PAYLOAD, WR_DROP} wr_state_t;

   logic [64:0] mem [DEPTH];
   logic [64:0] rd_word_q;

   wr_state_t state_q, state_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] commit_ptr_q, commit_ptr_d;
   logic [PW-1:0] pkt_start_q, pkt_start_d;
   logic [PW-1:0] pkt_count_q, pkt_count_d;
   logic          out_valid_q, out_valid_d;
   logic          drop_pulse_q, drop_pulse_d;
   logic [DROP_CNT_WIDTH-1:0] drop_count_q, drop_count_d;

   logic        full, in_hs, wr_en, commit, drop, is_local;
   logic        avail, load, release_pkt;
   logic [15:0] idx;

   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign axis_in_tready = reset_n && ((state_q == WR_DROP) || !full);
   assign in_hs = axis_in_tvalid && axis_in_tready;
   assign idx = axis_in_tdata[39:24] - address_offset;
   assign is_local = idx < NK;

   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      pkt_start_d  = pkt_start_q;
      commit_ptr_d = commit_ptr_q;
      wr_en        = 1'b0;
      commit       = 1'b0;
      drop         = 1'b0;
      case (state_q)
         WR_HEADER: begin
            if (in_hs) begin
               if (is_local) begin
                  wr_en       = 1'b1;
                  pkt_start_d = wr_ptr_q;
                  if (axis_in_tlast) commit = 1'b1;
                  else               state_d = WR_PAYLOAD;
               end else begin
                  drop = 1'b1;
                  if (!axis_in_tlast) state_d = WR_DROP;
               end
            end
         end
         WR_PAYLOAD: begin
            // A packet larger than the whole buffer can never drain: rewind and discard it.
            if (full && (pkt_count_q == '0)) begin
               wr_ptr_d = pkt_start_q;
               drop     = 1'b1;
               state_d  = WR_DROP;
            end else if (in_hs) begin
               wr_en = 1'b1;
               if (axis_in_tlast) begin
                  commit  = 1'b1;
                  state_d = WR_HEADER;
               end
            end
         end
         WR_DROP: begin
            if (in_hs && axis_in_tlast) state_d = WR_HEADER;
         end
         default: state_d = WR_HEADER;
      endcase
      if (wr_en)  wr_ptr_d     = wr_ptr_q + PW'(1);
      if (commit) commit_ptr_d = wr_ptr_q + PW'(1);
   end

   // Only beats below commit_ptr belong to complete packets and may be read out.
   assign avail       = (rd_ptr_q != commit_ptr_q);
   assign load        = avail && (!out_valid_q || axis_handler_tready);
   assign release_pkt = out_valid_q && axis_handler_tready && rd_word_q[64];

   always_comb begin
      rd_ptr_d    = rd_ptr_q;
      out_valid_d = out_valid_q;
      if (load) begin
         rd_ptr_d    = rd_ptr_q + PW'(1);
         out_valid_d = 1'b1;
      end else if (out_valid_q && axis_handler_tready) begin
         out_valid_d = 1'b0;
      end
      pkt_count_d = pkt_count_q;
      if (commit && !release_pkt)      pkt_count_d = pkt_count_q + PW'(1);
      else if (!commit && release_pkt) pkt_count_d = pkt_count_q - PW'(1);
      drop_pulse_d = drop;
      drop_count_d = drop_count_q;
      if (drop && (drop_count_q != '1)) drop_count_d = drop_count_q + DROP_CNT_WIDTH'(1);
   end

   always_ff @(posedge clock) begin
      if (wr_en) mem[wr_ptr_q[AW-1:0]] <= {axis_in_tlast, axis_in_tdata};
      if (load)  rd_word_q <= mem[rd_ptr_q[AW-1:0]];
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q      <= WR_HEADER;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         commit_ptr_q <= '0;
         pkt_start_q  <= '0;
         pkt_count_q  <= '0;
         out_valid_q  <= 1'b0;
         drop_pulse_q <= 1'b0;
         drop_count_q <= '0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         commit_ptr_q <= commit_ptr_d;
         pkt_start_q  <= pkt_start_d;
         pkt_count_q  <= pkt_count_d;
         out_valid_q  <= out_valid_d;
         drop_pulse_q <= drop_pulse_d;
         drop_count_q <= drop_count_d;
      end
   end

   assign axis_handler_tdata  = rd_word_q[63:0];
   assign axis_handler_tlast  = rd_word_q[64];
   assign axis_handler_tvalid = out_valid_q;
   assign drop_pulse          = drop_pulse_q;
   assign drop_count          = drop_count_q;
endmodule
